// File: rtl/tx_com_idle_ser_if.sv
// rtl/tx_com_idle_ser_if.sv - byte-side handshake and serial-line bundle for tx_com_idle_ser
//
// Signals:
//    data_in    [7:0]  byte to transmit (source -> serializer)
//    valid_in          data_in is valid (source -> serializer)
//    ready_out         serializer takes data_in at this edge if valid_in is high
//    data_out          registered serial bit, MSB first
//    sym_start         high while data_out carries bit 7 of a symbol
//    active_tx         training burst complete, data may flow
//    idle_count [7:0]  saturating count of IDLE fill slots (only with TX_IDLE_CNT_EN)
//
// Modports: master = byte source / line observer, slave = serializer.
interface tx_com_idle_ser_if;
   logic [7:0] data_in;
   logic       valid_in;
   logic       ready_out;
   logic       data_out;
   logic       sym_start;
   logic       active_tx;
`ifdef TX_IDLE_CNT_EN
   logic [7:0] idle_count;
`endif

   modport master (
      output data_in, valid_in,
      input  ready_out, data_out, sym_start, active_tx
`ifdef TX_IDLE_CNT_EN
      , input idle_count
`endif
   );

   modport slave (
      input  data_in, valid_in,
      output ready_out, data_out, sym_start, active_tx
`ifdef TX_IDLE_CNT_EN
      , output idle_count
`endif
   );
endinterface

// File: rtl/tx_com_idle_ser.sv
// rtl/tx_com_idle_ser.sv - single-lane COM-training / IDLE-filling transmit serializer
//
// After reset sends BC_COUNT COM symbols, then one IDLE that raises active_tx.
// From then on every 8-cycle symbol slot carries either an accepted data byte
// or IDLE, shifted out MSB first, one bit per clock.
//
// Ports:
//    clk     single clock, one serial bit per cycle
//    reset   asynchronous active-low reset
//    s_if    tx_com_idle_ser_if.slave: data_in/valid_in/ready_out byte handshake,
//            data_out/sym_start/active_tx serial line outputs
//
// Optional build macro TX_IDLE_CNT_EN adds s_if.idle_count, a saturating
// count of slots filled with IDLE (the training-exit IDLE included).
module tx_com_idle_ser #(
   parameter logic [7:0] COM      = 8'hBC,
   parameter logic [7:0] IDLE     = 8'h7C,
   parameter int         BC_COUNT = 4
) (
   input logic              clk,
   input logic              reset,
   tx_com_idle_ser_if.slave s_if
);

   localparam logic [3:0] LP_BC = 4'(BC_COUNT);

   typedef enum logic {
      ST_TRAIN,
      ST_ACTIVE
   } state_t;

   state_t     r_state;
   logic [7:0] r_shreg;
   logic [2:0] r_bit_cnt;
   logic [3:0] r_com_cnt;
   logic       r_data_out;
   logic       r_sym_start;
   logic       r_active_tx;

   logic       w_load;
   logic [7:0] w_sym;

   // A new symbol is chosen whenever the previous one has shifted its last bit.
   assign w_load = (r_bit_cnt == 3'd7);

   // Symbol chosen for the slot that starts at this edge.
   always_comb begin
      w_sym = IDLE;
      if (r_state == ST_TRAIN) begin
         if (r_com_cnt < LP_BC) begin
            w_sym = COM;
         end
      end else if (s_if.valid_in) begin
         w_sym = s_if.data_in;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_TRAIN;
         r_shreg     <= 8'h00;
         r_bit_cnt   <= 3'd7;
         r_com_cnt   <= 4'd0;
         r_data_out  <= 1'b0;
         r_sym_start <= 1'b0;
         r_active_tx <= 1'b0;
      end else if (w_load) begin
         r_data_out  <= w_sym[7];
         r_shreg     <= {w_sym[6:0], 1'b0};
         r_bit_cnt   <= 3'd0;
         r_sym_start <= 1'b1;
         if (r_state == ST_TRAIN) begin
            if (r_com_cnt < LP_BC) begin
               r_com_cnt <= r_com_cnt + 4'd1;
            end else begin
               // Training-exit slot carries IDLE; com_cnt stays at BC_COUNT.
               r_state     <= ST_ACTIVE;
               r_active_tx <= 1'b1;
            end
         end
      end else begin
         r_data_out  <= r_shreg[7];
         r_shreg     <= {r_shreg[6:0], 1'b0};
         r_bit_cnt   <= r_bit_cnt + 3'd1;
         r_sym_start <= 1'b0;
      end
   end

`ifdef TX_IDLE_CNT_EN
   logic       w_fill;
   logic [7:0] r_idle_cnt;

   // IDLE is chosen on training exit, or in ACTIVE when nothing is offered.
   assign w_fill = (r_state == ST_TRAIN) ? (r_com_cnt >= LP_BC) : !s_if.valid_in;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_idle_cnt <= 8'h00;
      end else if (w_load && w_fill && (r_idle_cnt != 8'hFF)) begin
         r_idle_cnt <= r_idle_cnt + 8'd1;
      end
   end

   assign s_if.idle_count = r_idle_cnt;
`endif

   // Purely from registers: the source may look at ready before deciding valid.
   assign s_if.ready_out = (r_state == ST_ACTIVE) && w_load;
   assign s_if.data_out  = r_data_out;
   assign s_if.sym_start = r_sym_start;
   assign s_if.active_tx = r_active_tx;

endmodule

// File: tb/tb_tx_com_idle_ser.sv
// tb/tb_tx_com_idle_ser.sv - self-checking bench for tx_com_idle_ser
module tb_tx_com_idle_ser;

   localparam int         BC_COUNT = 4;
   localparam logic [7:0] COM      = 8'hBC;
   localparam logic [7:0] IDLE     = 8'h7C;

   logic clk;
   logic reset;

   tx_com_idle_ser_if bus ();

   tx_com_idle_ser #(
      .COM      (COM),
      .IDLE     (IDLE),
      .BC_COUNT (BC_COUNT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .s_if  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: the line is a sequence of 8-edge slots counted from the
   // first edge after reset release; slot k starts at edge 8k+1.
   int         edge_n = 0;
   logic [7:0] cur_sym = 8'h00;
   int         fills = 0;
   logic [7:0] q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs at the negedge, predict, then check after the edge.
   task automatic step(input logic v, input logic [7:0] d, output bit acc);
      bit exp_load;
      bit exp_ready;
      int k;
      int pos;
      bus.valid_in = v;
      bus.data_in  = d;
      exp_load  = (edge_n % 8) == 0;
      exp_ready = exp_load && ((edge_n / 8) >= BC_COUNT + 1);
      check("ready_out", 32'(bus.ready_out), 32'(exp_ready));
      acc = exp_ready && v;
      @(posedge clk);
      edge_n++;
      k = (edge_n - 1) / 8;
      if (exp_load) begin
         if (k < BC_COUNT) begin
            cur_sym = COM;
         end else if (k == BC_COUNT) begin
            cur_sym = IDLE;
            fills++;
         end else if (v) begin
            cur_sym = d;
         end else begin
            cur_sym = IDLE;
            fills++;
         end
      end
      @(negedge clk);
      pos = (edge_n - 1) % 8;
      check("data_out", 32'(bus.data_out), 32'(cur_sym[7 - pos]));
      check("sym_start", 32'(bus.sym_start), 32'(pos == 0));
      check("active_tx", 32'(bus.active_tx), 32'(k >= BC_COUNT));
`ifdef TX_IDLE_CNT_EN
      check("idle_count", 32'(bus.idle_count), 32'((fills > 255) ? 255 : fills));
`endif
   endtask

   // Source: offers the head of q (optionally with random gaps), pops on accept.
   task automatic run(input int n, input bit gaps);
      bit acc;
      logic v;
      logic [7:0] d;
      for (int i = 0; i < n; i++) begin
         v = (q.size() > 0) && (!gaps || ($urandom_range(0, 1) == 1));
         d = (q.size() > 0) ? q[0] : 8'($urandom);
         step(v, d, acc);
         if (acc) void'(q.pop_front());
      end
   endtask

   task automatic drain(input string tag, input int budget);
      for (int i = 0; i < budget && q.size() > 0; i++) run(1, 0);
      check(tag, 32'(q.size()), 32'd0);
   endtask

   task automatic restart();
      reset = 1'b1;
      edge_n = 0;
      fills = 0;
      cur_sym = 8'h00;
   endtask

   initial begin
      reset = 1'b0;
      bus.valid_in = 1'b0;
      bus.data_in  = 8'h00;
      q.delete();
      @(negedge clk);
      @(negedge clk);
      check("rst_data_out", 32'(bus.data_out), 32'd0);
      check("rst_sym_start", 32'(bus.sym_start), 32'd0);
      check("rst_active_tx", 32'(bus.active_tx), 32'd0);
      check("rst_ready_out", 32'(bus.ready_out), 32'd0);
`ifdef TX_IDLE_CNT_EN
      check("rst_idle_count", 32'(bus.idle_count), 32'd0);
`endif
      restart();

      // Training burst, exit IDLE, then idle fill.
      run(56, 0);

      // Single byte, then IDLE again.
      q.push_back(8'hA5);
      drain("a5_accept", 16);
      run(16, 0);

      // Back-to-back stream: all three bytes must leave within 3 consecutive slots.
      q.push_back(8'h01);
      q.push_back(8'hFF);
      q.push_back(8'h3C);
      drain("stream_contig", 24);
      run(8, 0);

      // Exactly one load edge with valid low between 55 and AA.
      q.push_back(8'h55);
      drain("b55_accept", 16);
      run(8, 0);
      q.push_back(8'hAA);
      drain("baa_accept", 8);
      run(8, 0);

      // COM and IDLE values as data are sent verbatim.
      q.push_back(8'hBC);
      q.push_back(8'h7C);
      drain("verbatim", 16);
      run(8, 0);

      // Random bytes with valid toggling at random, mid-slot included.
      for (int i = 0; i < 24; i++) q.push_back(8'($urandom));
      run(400, 1);
      q.delete();
      run(8, 0);

`ifdef TX_IDLE_CNT_EN
      run(2400, 0);
      check("idle_sat", 32'(bus.idle_count), 32'd255);
`endif

      // Reset in the middle of a data symbol.
      q.push_back(8'hC3);
      drain("c3_accept", 16);
      run(3, 0);
      #1;
      reset = 1'b0;
      #1;
      check("midrst_data_out", 32'(bus.data_out), 32'd0);
      check("midrst_sym_start", 32'(bus.sym_start), 32'd0);
      check("midrst_active_tx", 32'(bus.active_tx), 32'd0);
      check("midrst_ready_out", 32'(bus.ready_out), 32'd0);
      @(negedge clk);
      @(negedge clk);
      check("midrst_hold", 32'(bus.data_out), 32'd0);
      restart();
      q.push_back(8'h96);
      run(64, 0);
      check("post_rst_sent", 32'(q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
